// File: rtl/uart_pkg.sv
// Shared types and the round-robin helper for the UART TX arbiter.
// Supports up to eight requesters.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  // Candidates are visited from farthest to nearest.
  // The one nearest to last+1 is assigned last, so it wins.
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] mask,
                                         input logic [2:0]         last,
                                         input int                 n);
    logic [2:0] win;
    logic [2:0] pos;
    win = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        pos = 3'((int'(last) + k) % n);
        if (mask[pos]) win = pos;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
// The scan starts just after the most recent owner and wraps.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [MAX_REQ-1:0] mask_ext;
  logic [2:0]         last_ext;
  logic [2:0]         win_ext;

  always_comb begin
    mask_ext                = '0;
    mask_ext[NUM_REQ-1:0]   = req_mask;
    last_ext                = '0;
    last_ext[IDX_W-1:0]     = last_grant;
    win_ext                 = rr_next(mask_ext, last_ext, NUM_REQ);
    winner                  = win_ext[IDX_W-1:0];
    any_req                 = |req_mask;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte stream.
// A stall watchdog releases the grant when the owner stops mid-packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  byte_t            tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             timeout_err_q, timeout_err_d;

  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             slot_free;
  logic             accept;
  byte_t            g_data;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_mask   (req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign slot_free = !tx_valid_q || tx_ready;
  assign accept    = (state_q == ARB_LOCKED) && slot_free && req_valid[grant_q];
  assign g_data    = req_data[8*int'(grant_q) +: 8];

  always_comb begin
    req_ready = '0;
    if ((state_q == ARB_LOCKED) && slot_free) req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    stall_d       = stall_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    timeout_err_d = 1'b0;

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
    if (accept) begin
      tx_data_d  = g_data;
      tx_valid_d = 1'b1;
    end

    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_LOCKED;
          grant_d = winner;
          stall_d = '0;
        end
      end
      ARB_LOCKED: begin
        // An accept on the threshold cycle takes priority over the watchdog.
        if (accept) begin
          stall_d = '0;
          if (req_last[grant_q]) begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_q;
          end
        end else if (stall_q == STALL_MAX) begin
          state_d       = ARB_IDLE;
          last_grant_d  = grant_q;
          timeout_err_d = 1'b1;
          stall_d       = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      stall_q       <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      stall_q       <= stall_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign grant_id    = grant_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q == ARB_LOCKED) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with two requesters and an 8-cycle watchdog.
// Requester queues feed the DUT; a monitor pops expected bytes on every transfer.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Requester model: handshake sampled at negedge, queues advanced 2 units after posedge.
  initial begin
    logic [1:0] fire;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #2;
      if (fire[0] && src0.size() > 0) void'(src0.pop_front());
      if (fire[1] && src1.size() > 0) void'(src1.pop_front());
      if (src0.size() > 0) begin
        req_valid[0] = 1'b1; req_data[7:0] = src0[0][7:0]; req_last[0] = src0[0][8];
      end else begin
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
      end
      if (src1.size() > 0) begin
        req_valid[1] = 1'b1; req_data[15:8] = src1[0][7:0]; req_last[1] = src1[0][8];
      end else begin
        req_valid[1] = 1'b0; req_last[1] = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got %h expected nothing", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL scoreboard_order: got %h expected %h", tx_data, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    src0.delete();
    src1.delete();
  endtask

  task automatic wait_byte(input logic [7:0] v);
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (tx_valid && tx_data == v) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL wait_byte: got none expected %h", v); end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy=%0d pending=%0d expected drained", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout_err); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    step();
    for (int i = 0; i < 4; i++) begin
      src0.push_back({(i == 3), 8'(8'h61 + i)});
      exp_q.push_back(8'(8'h61 + i));
    end
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_arb_ready: got %b expected 00", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_lock_ready: got %b expected 01", req_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", tx_valid); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h61 + i)) begin
        errors++; $display("FAIL single_stream: got %b/%h expected 1/%h", tx_valid, tx_data, 8'(8'h61 + i));
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    wait_idle();
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      step();
      src0.push_back({1'b0, 8'hA1}); src0.push_back({1'b1, 8'hA2});
      src1.push_back({1'b0, 8'hB1}); src1.push_back({1'b1, 8'hB2});
      exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
      exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
      wait_idle();
      checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rr_last_owner: got %0d expected 1", grant_id); end
    end
  endtask

  task automatic test_back_pressure();
    step();
    src0.push_back({1'b0, 8'h61}); src0.push_back({1'b0, 8'h62}); src0.push_back({1'b1, 8'h63});
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    wait_byte(8'h61);
    step();
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h62) begin
        errors++; $display("FAIL bp_hold: got %b/%h expected 1/62", tx_valid, tx_data);
      end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready: got %b expected 00", req_ready); end
    end
    step();
    tx_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_timeout();
    reset_dut();
    step();
    src0.push_back({1'b0, 8'h41});
    src1.push_back({1'b1, 8'hC1});
    exp_q.push_back(8'h41); exp_q.push_back(8'hC1);
    wait_byte(8'h41);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0 at stall %0d", timeout_err, k + 1); end
    end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy %b expected 0", busy); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_one_shot: got %b expected 0", timeout_err); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL to_regrant: got %0d expected 1", grant_id); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL to_ready: got %b expected 10", req_ready); end
    wait_idle();
  endtask

  task automatic test_timeout_boundary();
    reset_dut();
    step();
    src0.push_back({1'b0, 8'h41});
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    wait_byte(8'h41);
    repeat (7) step();
    src0.push_back({1'b1, 8'h42});
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tb_ready: got %b expected 01", req_ready); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tb_no_timeout: got %b expected 0", timeout_err); end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
      errors++; $display("FAIL tb_accept: got %b/%h expected 1/42", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tb_no_timeout_late: got %b expected 0", timeout_err); end
    wait_idle();
  endtask

  task automatic test_reset_mid_packet();
    step();
    src1.push_back({1'b0, 8'h61}); src1.push_back({1'b0, 8'h62}); src1.push_back({1'b1, 8'h63});
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    wait_byte(8'h61);
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    checks++; if (tx_data !== 8'h62 || grant_id !== 1'b1) begin errors++; $display("FAIL mid_hold: got %h/%0d expected 62/1", tx_data, grant_id); end
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL mid_grant: got %0d expected 0", grant_id); end
    checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL mid_pending: got %0d expected 2", exp_q.size()); end
    exp_q.delete();
    step();
    rst = 1'b0;
    tx_ready = 1'b1;
    src0.delete();
    src1.delete();
    src1.push_back({1'b1, 8'hD1});
    src0.push_back({1'b1, 8'hE1});
    exp_q.push_back(8'hE1); exp_q.push_back(8'hD1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (grant_id !== 1'b0 || req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %0d/%b expected 0/01", grant_id, req_ready); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, for example the command controller's response path and a status/error reporter.
- Uses round-robin arbitration with packet lock: a grant is held from the first byte through the byte flagged last, so packets never interleave on the wire.
- A watchdog releases a grant whose owner stalls mid-packet.
- Sits between the requesters and the UART TX valid/ready interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, consecutive no-transfer cycles while locked before the grant is forcibly released (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req_data  in  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  per-requester last-byte-of-packet flag, qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- tx_data  out  8  byte to UART TX; registered.
- tx_valid  out  1  byte valid to UART TX; registered.
- tx_ready  in  1  UART TX accept.
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner.
- busy  out  1  high when state==LOCKED or tx_valid.
- timeout_err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset values (rst high at a clk edge): state IDLE, tx_valid 0, tx_data 0, grant_id 0, last_grant NUM_REQ-1, stall counter 0, timeout_err 0.
- Reset mid-packet discards any held byte with no partial flush.
- Clock and reset: one clock domain; reset is synchronous, active-high.
- Output slot is a single register. slot_free = !tx_valid || tx_ready.
  - A transfer to UART occurs when tx_valid && tx_ready. If no new byte is loaded that cycle, tx_valid clears next cycle.
  - tx_data and tx_valid are held stable while tx_valid && !tx_ready.
- req_ready[i] = (state==LOCKED) && (grant_id==i) && slot_free. All other req_ready bits are 0.
- An accept occurs when req_valid[g] && req_ready[g]. On an accept, next cycle tx_data=req_data[g] and tx_valid=1.
- State IDLE:
  - If any req_valid is high, the winner is the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Next cycle: state=LOCKED, grant_id=winner, stall counter=0.
  - No byte is accepted in IDLE, so arbitration costs 1 cycle.
  - If no req_valid is high, stay in IDLE.
- State LOCKED:
  - Accept with req_last[g]=1: next state IDLE, last_grant=g. Back-to-back packets from different requesters are therefore separated by one arbitration cycle.
  - Accept with req_last[g]=0: stay LOCKED, stall counter=0.
  - No accept: stall counter +1. If the counter equals TIMEOUT_CYCLES-1, instead go to IDLE, set last_grant=g, pulse timeout_err high for the next cycle, and clear the counter.
  - An accept in the same cycle as the threshold wins; no timeout occurs.
  - Back-pressure from tx_ready=0 also counts as stall time.
- Latency: req_valid rising in IDLE at cycle 0 gives req_ready at cycle 1 (if slot free). The byte appears on tx_data/tx_valid at cycle 2.
- Throughput: one byte per cycle while locked and tx_ready=1.
- grant_id holds its value through IDLE until the next arbitration.
- Requester changes to req_valid of non-granted requesters have no effect while LOCKED.

Decomposition:
- Shared package uart_pkg holds:
  - typedef byte_t (logic [7:0]).
  - enum arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - function rr_next(mask, last) returning the round-robin winner index.
- One sub-module: rr_picker, combinational round-robin priority encoder taking req mask and last_grant and returning winner index and any_req.

Test Plan:
- Single requester: NUM_REQ=2; req0 sends 0x61,0x62,0x63,0x64 (last on 0x64), tx_ready=1 → tx_data shows 61,62,63,64 on consecutive cycles starting 2 cycles after req_valid; grant_id=0; busy falls one cycle after 0x64 drains.
- Round robin: both requesters hold 2-byte packets (0xA1,0xA2) and (0xB1,0xB2) after reset → output order A1 A2 B1 B2. Repeating both → next packet starts with requester 0 again after 1 (alternation holds).
- Back-pressure: tx_ready=0 for 5 cycles while 0x62 is held → tx_data stays 0x62, tx_valid stays 1, req_ready=0. On tx_ready=1 the stream resumes with no loss or duplication.
- Timeout: TIMEOUT_CYCLES=8; req0 sends 0x41 without last, then drops req_valid → exactly 8 no-transfer cycles later timeout_err pulses once, state returns IDLE, and a pending req1 packet is granted next.
- Timeout boundary: req0 presents a byte on the exact threshold cycle → byte accepted, no timeout_err.
- Reset mid-packet: assert rst while 0x62 is held with tx_ready=0 → next cycle tx_valid=0, busy=0, grant_id=0. After release, req1 and req0 both requesting → req0 is granted first.
